// File: rtl/zf_read_arbiter.sv
// zf_read_arbiter: round-robin arbiter serializing two AXI-lite read masters onto one slave,
// one outstanding read at a time, with saturating per-master grant counters.
module zf_read_arbiter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          m0_araddr,
  input  logic                 m0_arvalid,
  output logic                 m0_arready,
  output logic [31:0]          m0_rdata,
  output logic [1:0]           m0_rresp,
  output logic                 m0_rvalid,
  input  logic                 m0_rready,
  input  logic [31:0]          m1_araddr,
  input  logic                 m1_arvalid,
  output logic                 m1_arready,
  output logic [31:0]          m1_rdata,
  output logic [1:0]           m1_rresp,
  output logic                 m1_rvalid,
  input  logic                 m1_rready,
  output logic [31:0]          s_araddr,
  output logic                 s_arvalid,
  input  logic                 s_arready,
  input  logic [31:0]          s_rdata,
  input  logic [1:0]           s_rresp,
  input  logic                 s_rvalid,
  output logic                 s_rready,
  output logic [CNT_WIDTH-1:0] m0_count,
  output logic [CNT_WIDTH-1:0] m1_count,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t               state_q, state_d;
  logic                 gnt_q, gnt_d, last_q, last_d;
  logic                 sel, accept, done, in_data;
  logic [31:0]          s_araddr_q, s_araddr_d;
  logic [CNT_WIDTH-1:0] m0_count_q, m0_count_d, m1_count_q, m1_count_d;
  always_comb begin
    sel        = (m0_arvalid && m1_arvalid) ? ~last_q : m1_arvalid;
    accept     = state_q == IDLE && (m0_arvalid || m1_arvalid) && !rst;
    in_data    = state_q == DATA;
    done       = in_data && s_rvalid && s_rready;
    state_d    = accept ? ADDR : (state_q == ADDR && s_arready) ? DATA : done ? IDLE : state_q;
    gnt_d      = accept ? sel : gnt_q;
    last_d     = done ? gnt_q : last_q;
    s_araddr_d = accept ? (sel ? m1_araddr : m0_araddr) : s_araddr_q;
    m0_count_d = (done && !gnt_q && !(&m0_count_q)) ? m0_count_q + CNT_WIDTH'(1) : m0_count_q;
    m1_count_d = (done && gnt_q && !(&m1_count_q)) ? m1_count_q + CNT_WIDTH'(1) : m1_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      s_araddr_q <= '0;
      m0_count_q <= '0;
      m1_count_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      s_araddr_q <= s_araddr_d;
      m0_count_q <= m0_count_d;
      m1_count_q <= m1_count_d;
    end
  end
  assign m0_arready = accept && !sel;
  assign m1_arready = accept && sel;
  assign s_araddr   = s_araddr_q;
  assign s_arvalid  = state_q == ADDR;
  assign s_rready   = in_data && (gnt_q ? m1_rready : m0_rready);
  assign m0_rvalid  = in_data && !gnt_q && s_rvalid;
  assign m1_rvalid  = in_data && gnt_q && s_rvalid;
  assign m0_rresp   = (in_data && !gnt_q) ? s_rresp : 2'b00;
  assign m1_rresp   = (in_data && gnt_q) ? s_rresp : 2'b00;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_count   = m0_count_q;
  assign m1_count   = m1_count_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_zf_read_arbiter.sv
// tb_zf_read_arbiter: transaction-level reference model checked every cycle, plus directed scenarios.
module tb_zf_read_arbiter;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  logic [1:0] arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] araddr0 = 0, araddr1 = 0, rdata0, rdata1, s_araddr, s_rdata = 0;
  logic [1:0] rresp0, rresp1, s_rresp = 0;
  logic s_arvalid, s_arready = 0, s_rvalid = 0, s_rready, busy;
  logic [CW-1:0] m0_count, m1_count;

  zf_read_arbiter #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(araddr0), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]), .m0_rdata(rdata0),
    .m0_rresp(rresp0), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
    .m1_araddr(araddr1), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]), .m1_rdata(rdata1),
    .m1_rresp(rresp1), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m0_count(m0_count), .m1_count(m1_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0, done = 0;
  // stimulus knobs
  logic rst_req = 1, rnd = 0, hold_both = 0;
  logic [1:0] want = 0;
  logic [31:0] adr[2] = '{0, 0};
  int lat = 2, rr_block = 0, resp_fix = -1;
  logic dat_fix_en = 0;
  logic [31:0] dat_fix = 0;
  // downstream slave model
  logic s_pend = 0;
  int s_cnt = 0;
  logic [31:0] sd = 0;
  logic [1:0] sr = 0;
  // reference model: transaction phase 0 none, 1 address outstanding, 2 awaiting data
  int ph = 0, g = 0, lst = 1;
  logic [31:0] maddr = 0;
  int mc[2] = '{0, 0};
  // observations
  int ev_acc = -1, ev_sav = -1, ev_rv = -1, blk_obs = 0;
  logic [31:0] ev_rd = 0;
  logic [1:0] resp_obs = 0;
  logic [31:0] ar_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    int w;
    logic hs_ar, hs_r;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    arvalid = want;
    araddr0 = adr[0];
    araddr1 = adr[1];
    rready[0] = rr_block > 0 ? 1'b0 : (rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1);
    rready[1] = rr_block > 0 ? 1'b0 : (rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1);
    s_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    s_rvalid = s_pend && s_cnt == 0;
    s_rdata = s_rvalid ? sd : $urandom;
    s_rresp = s_rvalid ? sr : 2'($urandom);
    #1;
    w = (want == 2'b11) ? 1 - lst : int'(want[1]);
    chk("m0_arready", arready[0], !rst && ph == 0 && want[0] && w == 0);
    chk("m1_arready", arready[1], !rst && ph == 0 && want[1] && w == 1);
    chk("s_arvalid", s_arvalid, ph == 1);
    chk("s_araddr", s_araddr, maddr);
    chk("s_rready", s_rready, ph == 2 && rready[g]);
    chk("m0_rvalid", rvalid[0], ph == 2 && g == 0 && s_rvalid);
    chk("m1_rvalid", rvalid[1], ph == 2 && g == 1 && s_rvalid);
    chk("m0_rresp", rresp0, (ph == 2 && g == 0) ? s_rresp : 2'b00);
    chk("m1_rresp", rresp1, (ph == 2 && g == 1) ? s_rresp : 2'b00);
    chk("m0_rdata", rdata0, s_rdata);
    chk("m1_rdata", rdata1, s_rdata);
    chk("busy", busy, ph != 0);
    chk("m0_count", m0_count, mc[0]);
    chk("m1_count", m1_count, mc[1]);
    if (arready[0] && ev_acc < 0) ev_acc = cyc;
    if (s_arvalid && ev_sav < 0) ev_sav = cyc;
    if (rvalid[0] && ev_rv < 0) begin ev_rv = cyc; ev_rd = rdata0; end
    if (s_arvalid && s_arready) ar_log.push_back(s_araddr);
    if (rvalid[0] || rvalid[1]) resp_obs = rvalid[0] ? rresp0 : rresp1;
    if (rvalid[1] && !s_rready) begin
      blk_obs++;
      chk("m1_rdata_hold", rdata1, sd);
    end
    hs_ar = ph == 1 && s_arready;
    hs_r  = ph == 2 && s_rvalid && rready[g];
    if (rr_block > 0 && s_rvalid) rr_block--;
    if (rst) begin
      ph = 0; g = 0; lst = 1; maddr = 0; mc[0] = 0; mc[1] = 0; s_pend = 0;
    end else if (ph == 0 && want != 0) begin
      g = w; maddr = adr[g]; want[g] = 1'b0; ph = 1;
    end else if (hs_ar) begin
      ph = 2; s_pend = 1;
      s_cnt = (lat < 0 ? int'($urandom_range(1, 3)) : lat) - 1;
      sd = dat_fix_en ? dat_fix : $urandom;
      sr = resp_fix >= 0 ? 2'(resp_fix) : 2'($urandom);
    end else if (hs_r) begin
      mc[g] = mc[g] == MAX ? MAX : mc[g] + 1;
      lst = g; ph = 0; s_pend = 0; done++;
    end else if (s_pend && s_cnt > 0) s_cnt--;
    if (hold_both) begin
      want = 2'b11; adr[0] = 32'h100; adr[1] = 32'h200;
    end else if (rnd) begin
      for (int n = 0; n < 2; n++)
        if (!want[n] && $urandom_range(0, 2) == 0) begin want[n] = 1'b1; adr[n] = $urandom; end
    end
  endtask

  task automatic reset_dut();
    rnd = 0; hold_both = 0; want = 0; lat = 2; rr_block = 0; resp_fix = 0; dat_fix_en = 0;
    rst_req = 1; step(); step(); rst_req = 0;
    done = 0; ev_acc = -1; ev_sav = -1; ev_rv = -1; blk_obs = 0; ar_log.delete();
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (done < n && k < budget) begin step(); k++; end
    chk("timeout", done >= n, 1);
  endtask

  initial begin
    // single M0 read and its latency
    reset_dut();
    dat_fix_en = 1; dat_fix = 32'hA5A5_0001;
    want[0] = 1; adr[0] = 32'h4000_0010;
    run_until(1, 20); step();
    chk("t1_sar_lat", ev_sav - ev_acc, 1);
    chk("t1_rv_lat", ev_rv - ev_acc, 3);
    chk("t1_rdata", ev_rd, 32'hA5A5_0001);
    chk("t1_araddr", ar_log.size() > 0 ? ar_log[0] : 0, 32'h4000_0010);
    chk("t1_cnt0", m0_count, 1);
    chk("t1_cnt1", m1_count, 0);
    // contention alternates
    reset_dut();
    hold_both = 1;
    run_until(6, 60);
    hold_both = 0; want = 0; step();
    chk("t2_log_size", ar_log.size(), 6);
    for (int i = 0; i < 6 && i < ar_log.size(); i++)
      chk("t2_order", ar_log[i], (i % 2) ? 32'h200 : 32'h100);
    chk("t2_cnt0", m0_count, 3);
    chk("t2_cnt1", m1_count, 3);
    // M1 backpressure, M0 waits
    reset_dut();
    lat = 1; rr_block = 5; dat_fix_en = 1; dat_fix = 32'hDEAD_BEEF;
    want[1] = 1; adr[1] = 32'h300;
    step();
    want[0] = 1; adr[0] = 32'h400;
    run_until(1, 30);
    chk("t3_blocked", blk_obs, 5);
    chk("t3_cnt0_wait", mc[0], 0);
    run_until(2, 30); step();
    chk("t3_cnt0", m0_count, 1);
    chk("t3_cnt1", m1_count, 1);
    // error response still counts
    reset_dut();
    resp_fix = 2;
    want[0] = 1; adr[0] = 32'h44;
    run_until(1, 20); step();
    chk("t4_rresp", resp_obs, 2'b10);
    chk("t4_cnt0", m0_count, 1);
    // saturation
    reset_dut();
    for (int i = 0; i < MAX + 2; i++) begin
      want[0] = 1; adr[0] = 32'h10 + i;
      run_until(i + 1, 20);
    end
    step();
    chk("t5_sat", m0_count, MAX);
    // reset while awaiting data
    reset_dut();
    lat = 5; want[0] = 1; adr[0] = 32'h80;
    for (int k = 0; k < 20 && ph != 2; k++) step();
    chk("t6_in_data", ph, 2);
    rst_req = 1; step(); rst_req = 0; step();
    chk("t6_busy", busy, 0);
    chk("t6_s_rready", s_rready, 0);
    chk("t6_rvalid", rvalid, 2'b00);
    chk("t6_cnts", {m0_count, m1_count}, 0);
    lat = 2; done = 0; want[1] = 1; adr[1] = 32'h55;
    run_until(1, 20); step();
    chk("t6_cnt1", m1_count, 1);
    // random traffic
    reset_dut();
    rnd = 1; lat = -1; resp_fix = -1;
    for (int k = 0; k < 3000; k++) begin
      rst_req = ($urandom_range(0, 399) == 0);
      step();
    end
    rst_req = 0;
    chk("rand_progress", done > 100, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
